// File: rtl/cordic_sincos_ctrl.sv
// cordic_sincos_ctrl: sequences quadrant correction, CORDIC rotation and quadrant fix-up for one sin/cos job
module cordic_sincos_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_z,
  output logic             corr_enable,
  output logic [WIDTH-1:0] corr_z,
  input  logic [WIDTH-1:0] corr_z_out,
  input  logic [2:0]       corr_quadrante,
  input  logic             corr_done,
  output logic             rot_start,
  output logic [WIDTH-1:0] rot_z,
  input  logic             rot_done,
  input  logic [WIDTH-1:0] rot_sin,
  input  logic [WIDTH-1:0] rot_cos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sin,
  output logic [WIDTH-1:0] out_cos,
  output logic [2:0]       out_quad,
  output logic             err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_V = ~MIN_V;

  typedef enum logic [2:0] {IDLE, CORR_GO, CORR_WAIT, ROT_GO, ROT_WAIT, FIXUP, OUT} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] corr_z_q, corr_z_d, rot_z_q, rot_z_d;
  logic [WIDTH-1:0] s_q, s_d, c_q, c_d;
  logic [WIDTH-1:0] out_sin_q, out_sin_d, out_cos_q, out_cos_d;
  logic [2:0] quad_q, quad_d, out_quad_q, out_quad_d;
  logic err_q, err_d, to;

  // the most negative value has no positive twin, so it clamps to the maximum
  function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] x);
    return (x == MIN_V) ? MAX_V : -x;
  endfunction

  assign in_ready    = (state_q == IDLE);
  assign corr_enable = (state_q == CORR_GO);
  assign rot_start   = (state_q == ROT_GO);
  assign out_valid   = (state_q == OUT);
  assign corr_z      = corr_z_q;
  assign rot_z       = rot_z_q;
  assign out_sin     = out_sin_q;
  assign out_cos     = out_cos_q;
  assign out_quad    = out_quad_q;
  assign err         = err_q;

  // next-state and datapath capture; done inputs only matter in their own wait state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    corr_z_d   = corr_z_q;
    rot_z_d    = rot_z_q;
    s_d        = s_q;
    c_d        = c_q;
    quad_d     = quad_q;
    out_sin_d  = out_sin_q;
    out_cos_d  = out_cos_q;
    out_quad_d = out_quad_q;
    err_d      = err_q;
    to         = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        corr_z_d = in_z;
        state_d  = CORR_GO;
      end
      CORR_GO: begin
        cnt_d   = '0;
        state_d = CORR_WAIT;
      end
      CORR_WAIT: if (corr_done) begin
        rot_z_d = corr_z_out;
        quad_d  = corr_quadrante;
        state_d = ROT_GO;
      end else if (cnt_q == CNT_MAX) to = 1'b1;
      else cnt_d = cnt_q + 1'b1;
      ROT_GO: begin
        cnt_d   = '0;
        state_d = ROT_WAIT;
      end
      ROT_WAIT: if (rot_done) begin
        s_d     = rot_sin;
        c_d     = rot_cos;
        state_d = FIXUP;
      end else if (cnt_q == CNT_MAX) to = 1'b1;
      else cnt_d = cnt_q + 1'b1;
      FIXUP: begin
        out_sin_d  = (quad_q == 3'd1) ? c_q :
                     (quad_q == 3'd2 || quad_q == 3'd3) ? neg_sat(s_q) :
                     (quad_q == 3'd4) ? neg_sat(c_q) : s_q;
        out_cos_d  = (quad_q == 3'd1) ? neg_sat(s_q) :
                     (quad_q == 3'd2 || quad_q == 3'd3) ? neg_sat(c_q) :
                     (quad_q == 3'd4) ? s_q : c_q;
        out_quad_d = (quad_q > 3'd4) ? 3'd0 : quad_q;
        err_d      = (quad_q > 3'd4);
        state_d    = OUT;
      end
      OUT: if (out_ready) begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (to) begin
      out_sin_d  = '0;
      out_cos_d  = '0;
      out_quad_d = '0;
      err_d      = 1'b1;
      state_d    = OUT;
    end
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      corr_z_q   <= '0;
      rot_z_q    <= '0;
      s_q        <= '0;
      c_q        <= '0;
      quad_q     <= '0;
      out_sin_q  <= '0;
      out_cos_q  <= '0;
      out_quad_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      corr_z_q   <= corr_z_d;
      rot_z_q    <= rot_z_d;
      s_q        <= s_d;
      c_q        <= c_d;
      quad_q     <= quad_d;
      out_sin_q  <= out_sin_d;
      out_cos_q  <= out_cos_d;
      out_quad_q <= out_quad_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_cordic_sincos_ctrl.sv
// tb_cordic_sincos_ctrl: directed and random jobs through stub corrector/core, checked against a quadrant model
module tb_cordic_sincos_ctrl;
  logic clk = 1'b0, rst, in_valid, in_ready, corr_enable, corr_done, rot_start, rot_done;
  logic out_valid, out_ready, err;
  logic [31:0] in_z, corr_z, corr_z_out, rot_z, rot_sin, rot_cos, out_sin, out_cos;
  logic [2:0] corr_quadrante, out_quad;
  logic corr_hang = 1'b0, rot_hang = 1'b0, rot_force = 1'b0;
  logic [2:0] q_tb = 3'd0;
  logic [31:0] s_tb = 32'd0, c_tb = 32'd0;
  int ccnt = 0, rcnt = 0, ce_cnt = 0;
  int errors = 0, checks = 0;

  cordic_sincos_ctrl #(.WIDTH(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .corr_enable(corr_enable), .corr_z(corr_z), .corr_z_out(corr_z_out),
    .corr_quadrante(corr_quadrante), .corr_done(corr_done), .rot_start(rot_start),
    .rot_z(rot_z), .rot_done(rot_done), .rot_sin(rot_sin), .rot_cos(rot_cos),
    .out_valid(out_valid), .out_ready(out_ready), .out_sin(out_sin), .out_cos(out_cos),
    .out_quad(out_quad), .err(err)
  );

  always #5 clk = ~clk;

  // stub corrector: done 3 cycles after its enable, echoes the angle
  always @(posedge clk) ccnt <= corr_enable ? 3 : (ccnt > 0 ? ccnt - 1 : 0);
  // stub core: done 5 cycles after its start
  always @(posedge clk) rcnt <= rot_start ? 5 : (rcnt > 0 ? rcnt - 1 : 0);
  always @(posedge clk) if (corr_enable) ce_cnt <= ce_cnt + 1;

  assign corr_done      = (ccnt == 1) && !corr_hang;
  assign corr_z_out     = corr_z;
  assign corr_quadrante = q_tb;
  assign rot_done       = ((rcnt == 1) && !rot_hang) || rot_force;
  assign rot_sin        = s_tb;
  assign rot_cos        = c_tb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nsat(input logic [31:0] x);
    longint v;
    v = -longint'($signed(x));
    return (v > 64'sd2147483647) ? 32'h7fffffff : 32'(v);
  endfunction

  // expected result: rotate (s, c) back by quadrant; codes above 4 behave as 0 and flag err
  task automatic model(input logic [2:0] q, input logic [31:0] s, input logic [31:0] c,
                       output logic [31:0] es, output logic [31:0] ec, output logic e);
    es = s; ec = c; e = (q > 3'd4);
    if (q == 3'd1) begin es = c; ec = nsat(s); end
    if (q == 3'd2 || q == 3'd3) begin es = nsat(s); ec = nsat(c); end
    if (q == 3'd4) begin es = nsat(c); ec = s; end
  endtask

  task automatic start(input logic [31:0] z, input bit keep);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept_ready", in_ready, 1);
    in_z = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = keep;
  endtask

  // lat is the cycle number (cycle 1 = the one right after the accept edge) where out_valid is first seen
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("err_clear", err, 0);
  endtask

  task automatic job(input string tag, input logic [31:0] z, input logic [2:0] q,
                     input logic [31:0] s, input logic [31:0] c);
    int lat;
    logic [31:0] es, ec;
    logic e;
    q_tb = q; s_tb = s; c_tb = c;
    model(q, s, c, es, ec, e);
    start(z, 1'b0);
    wait_out(lat);
    chk({tag, "_lat"}, lat, 4 + 3 + 5);
    chk({tag, "_sin"}, out_sin, es);
    chk({tag, "_cos"}, out_cos, ec);
    chk({tag, "_err"}, err, e);
    if (q <= 3'd4) chk({tag, "_quad"}, out_quad, q);
    chk({tag, "_corr_z"}, corr_z, z);
    chk({tag, "_rot_z"}, rot_z, z);
    handshake();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ce0;
    logic [31:0] hs, hc, z;
    logic [2:0] q;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_z = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_corr_en", corr_enable, 0);
    chk("rst_rot_start", rot_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_outs", {out_sin, out_cos}, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    job("q0", 32'd0, 3'd0, 32'd1000, 32'd2000);
    job("q1", 32'd100, 3'd1, 32'd1000, 32'd2000);
    chk("q1_lit", {out_sin, out_cos}, {32'd2000, -32'd1000});
    job("q2", 32'd200, 3'd2, 32'd1000, 32'd2000);
    job("q3", 32'd300, 3'd3, 32'd1000, 32'd2000);
    job("q4", 32'd400, 3'd4, 32'd1000, 32'd2000);
    chk("q4_lit", {out_sin, out_cos}, {-32'd2000, 32'd1000});
    job("sat", 32'd5, 3'd2, 32'h80000000, 32'd2000);
    chk("sat_lit", out_sin, 32'h7fffffff);
    job("sat4", 32'd6, 3'd4, 32'd7, 32'h80000000);
    job("illegal", 32'd7, 3'd6, 32'd11, 32'd22);

    // corrector never answers
    corr_hang = 1'b1; q_tb = 3'd2; s_tb = 32'd5; c_tb = 32'd6;
    start(32'd77, 1'b0);
    wait_out(lat);
    chk("ctmo_lat", lat, 2 + 64);
    chk("ctmo_err", err, 1);
    chk("ctmo_outs", {out_sin, out_cos, out_quad}, 0);
    handshake();
    corr_hang = 1'b0;
    job("after_ctmo", 32'd9, 3'd1, 32'd1000, 32'd2000);

    // core never answers
    rot_hang = 1'b1; q_tb = 3'd3;
    start(32'd78, 1'b0);
    wait_out(lat);
    chk("rtmo_lat", lat, 6 + 64);
    chk("rtmo_err", err, 1);
    chk("rtmo_outs", {out_sin, out_cos, out_quad}, 0);
    handshake();
    rot_hang = 1'b0;

    // backpressure with a second request held the whole time
    q_tb = 3'd1; s_tb = 32'd1234; c_tb = 32'd4321;
    ce0 = ce_cnt;
    start(32'd55, 1'b1);
    wait_out(lat);
    hs = out_sin; hc = out_cos;
    chk("hold_first", {hs, hc}, {32'd4321, nsat(32'd1234)});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_outs", {out_sin, out_cos}, {hs, hc});
    end
    chk("hold_one_job", ce_cnt - ce0, 1);
    in_z = 32'd56;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("hold_drop", out_valid, 0);
    chk("hold_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_next_accept", corr_enable, 1);
    wait_out(lat);
    chk("hold_second_z", corr_z, 32'd56);
    handshake();

    // reset in the middle of the rotation wait
    q_tb = 3'd4; s_tb = 32'd10; c_tb = 32'd20;
    start(32'd99, 1'b0);
    lat = 0;
    while (!rot_start && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("rst_reach_rot", rot_start, 1);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_pulses", {corr_enable, rot_start, out_valid, err}, 0);
    chk("mid_rst_regs", {corr_z, rot_z, out_sin, out_cos, out_quad}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rot_force = 1'b1;
    @(negedge clk); rot_force = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {out_valid, in_ready}, 2'b01);
    end
    job("after_rst", 32'd42, 3'd3, 32'd300, 32'd400);

    // random jobs
    for (int i = 0; i < 20; i++) begin
      z = $urandom;
      q = 3'($urandom_range(0, 4));
      hs = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      hc = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      job("rand", z, q, hs, hc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cordic_sincos_ctrl.md
# cordic_sincos_ctrl

Sequencer for one sin/cos evaluation. It takes an angle request over a valid/ready handshake and triggers the quadrant-correction stage (π/4 range reduction). It then starts the iterative CORDIC rotation core with the reduced angle and maps the core's sin/cos back to the original quadrant before presenting the result. It sits between the requesting datapath and the existing corrector/CORDIC pair, owns their start/done signalling, and guards each stage with a timeout.

## Interface
- WIDTH, 32: angle and sin/cos data width, signed Q16 fixed point (2π = 411775).
- TIMEOUT, 64: maximum cycles allowed in any single wait state before an error is flagged.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  the request angle on in_z is valid.
- in_ready  out  1  the controller accepts a request this cycle.
- in_z  in  WIDTH  request angle, signed, radians in Q16.
- corr_enable  out  1  one-cycle start pulse to the quadrant corrector.
- corr_z  out  WIDTH  angle sent to the corrector; held stable while a job is active.
- corr_z_out  in  WIDTH  reduced angle from the corrector, in [-π/4, π/4].
- corr_quadrante  in  3  quadrant code from the corrector, 0–4.
- corr_done  in  1  corrector result is valid; may be a one-cycle pulse.
- rot_start  out  1  one-cycle start pulse to the CORDIC core.
- rot_z  out  WIDTH  reduced angle sent to the core.
- rot_done  in  1  core result is valid; may be a one-cycle pulse.
- rot_sin, rot_cos  in  WIDTH  core outputs, signed.
- out_valid  out  1  result is valid.
- out_ready  in  1  the consumer accepts the result.
- out_sin, out_cos  out  WIDTH  quadrant-corrected results.
- out_quad  out  3  quadrant code used for this result.
- err  out  1  the result was produced after a stage timeout; outputs are 0 in that case.

## Operation
- States: IDLE, CORR_GO, CORR_WAIT, ROT_GO, ROT_WAIT, FIXUP, OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_z into corr_z and go to CORR_GO.
- CORR_GO: corr_enable=1 for exactly one cycle, clear the timeout counter, then go to CORR_WAIT.
- CORR_WAIT: on corr_done, latch corr_z_out into rot_z and corr_quadrante into a quadrant register, then go to ROT_GO.
- ROT_GO: rot_start=1 for one cycle, clear the timeout counter, then go to ROT_WAIT.
- ROT_WAIT: on rot_done, latch rot_sin and rot_cos, then go to FIXUP.
- FIXUP: map the latched s=rot_sin, c=rot_cos by quadrant code:
  - 0: sin=s, cos=c.
  - 1: sin=c, cos=-s.
  - 2 and 3: sin=-s, cos=-c.
  - 4: sin=-c, cos=s.
  - 5–7 (illegal): treat as 0 and set err.
- FIXUP then goes to OUT.
- Negation saturates: -(−2^(WIDTH-1)) = 2^(WIDTH-1)−1.
- OUT: out_valid=1. Outputs hold stable until out_ready. On out_valid&&out_ready go to IDLE; err clears on that handshake.
- Timeout: the counter increments each cycle in CORR_WAIT and ROT_WAIT. When it reaches TIMEOUT−1 without the matching done:
  - set err;
  - force out_sin=out_cos=0 and out_quad=0;
  - go to OUT.
- A done pulse arriving outside its matching wait state is ignored.
- If corr_done and rot_done are both high in the same cycle, only the one matching the current state is acted on.
- in_valid while busy: in_ready=0, and the request is not consumed.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE;
  - in_ready=1;
  - corr_enable=0, rot_start=0, out_valid=0, err=0;
  - corr_z, rot_z, out_sin, out_cos, out_quad all 0.
- Reset asserted mid-job aborts the job with no output. Pulses are never stretched across reset.
- in_ready and out_valid are registered (decoded from state). There are no combinational paths from inputs to outputs.
- Accept at edge N gives corr_enable high during cycle N+1.
- corr_done seen at edge M gives rot_start high during cycle M+1.
- rot_done seen at edge R gives out_valid high from cycle R+2 (one FIXUP cycle).
- Total latency = 4 + corrector cycles + core cycles.
- Throughput: one job in flight. Next accept is no earlier than the cycle after the output handshake.
- corr_z and rot_z stay stable from their start pulse until the next accept.

## Test plan
- Stub corrector returns (z, quad 0) after 3 cycles; stub core returns sin=1000, cos=2000 after 5 cycles. Send in_z=0 → out_sin=1000, out_cos=2000, out_quad=0, err=0. out_valid rises exactly 12 cycles after accept.
- Same core stub, corrector returns quad 1, 2, 3, 4 in turn:
  - quad 1 → (2000, −1000);
  - quad 2 and 3 → (−1000, −2000);
  - quad 4 → (−2000, 1000).
- Core stub returns sin=−2147483648 with quad 2 → out_sin=2147483647 (saturated).
- Corrector never asserts corr_done, TIMEOUT=64 → out_valid with err=1 and both outputs 0 after 64 wait cycles. After the handshake, the next request completes normally with err=0.
- Hold out_ready=0 for 10 cycles with in_valid high the whole time → outputs stable, in_ready=0, exactly one job accepted. The second request is accepted the cycle after the out handshake.
- Assert rst during ROT_WAIT, and send a spurious rot_done in IDLE → all outputs return to reset values immediately. No out_valid results, and the next job runs correctly.
